// File: rtl/rv_pkg.sv
// Shared RV32 core constants: datapath width, register count and ABI register names.
package rv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;
  localparam int unsigned AW   = $clog2(NREG);

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback side of the multi-port register file: read, write and issue-reservation signals.
interface regfile_mp_if #(
  parameter int unsigned XLEN = rv_pkg::XLEN,
  parameter int unsigned NREG = rv_pkg::NREG,
  parameter int unsigned NRD  = 2,
  parameter int unsigned NWR  = 1
) ();

  localparam int unsigned AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                sb_set;
  logic [AW-1:0]       sb_addr;
  logic [AW:0]         busy_cnt;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_busy, busy_cnt
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_busy, busy_cnt
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a running count of busy registers.
module regfile_scoreboard #(
  parameter int unsigned NREG    = rv_pkg::NREG,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter bit          ZERO_R0 = 1'b1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NWR-1:0]             wrValid,
  input  logic [NWR*$clog2(NREG)-1:0] wrAddrFlat,
  input  logic                       sbSet,
  input  logic [$clog2(NREG)-1:0]    sbAddr,
  input  logic [NRD*$clog2(NREG)-1:0] rdAddrFlat,
  output logic [NRD-1:0]             rdBusy,
  output logic [$clog2(NREG):0]      busyCnt
);

  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned CW = AW + 1;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] setVec;
  logic [NREG-1:0] clrVec;
  logic [NREG-1:0] busyNext;
  logic [CW-1:0]   nClr;
  logic            inc;
  logic [CW-1:0]   cntNext;

  // A new reservation supersedes a producer completing in the same cycle.
  always_comb begin
    setVec = '0;
    clrVec = '0;
    if (sbSet && !(ZERO_R0 && (sbAddr == AW'(rv_pkg::REG_ZERO)))) begin
      setVec[sbAddr] = 1'b1;
    end
    for (int unsigned k = 0; k < NWR; k++) begin
      if (wrValid[k]) begin
        clrVec[wrAddrFlat[k*AW +: AW]] = 1'b1;
      end
    end
    busyNext = (busy & ~clrVec) | setVec;
    if (ZERO_R0) begin
      busyNext[0] = 1'b0;
    end
  end

  // Count tracks popcount(busy) incrementally: one possible new set, any number of net clears.
  always_comb begin
    nClr = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      nClr = nClr + CW'(busy[i] & clrVec[i] & ~setVec[i]);
    end
    inc     = |(setVec & ~busy);
    cntNext = busyCnt + CW'(inc) - nClr;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy    <= '0;
      busyCnt <= '0;
    end else begin
      busy    <= busyNext;
      busyCnt <= cntNext;
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : gBusyRead
    assign rdBusy[p] = busy[rdAddrFlat[p*AW +: AW]];
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with same-cycle write bypass and an issue scoreboard.
module regfile_mp #(
  parameter int unsigned XLEN    = rv_pkg::XLEN,
  parameter int unsigned NREG    = rv_pkg::NREG,
  parameter int unsigned NRD     = 2,
  parameter int unsigned NWR     = 1,
  parameter bit          ZERO_R0 = 1'b1,
  parameter bit          BYPASS  = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  regfile_mp_if.slave bus
);

  localparam int unsigned AW = $clog2(NREG);

  logic [XLEN-1:0] regs  [NREG];
  logic [AW-1:0]   wAddr [NWR];
  logic [XLEN-1:0] wData [NWR];
  logic [NWR-1:0]  wrValid;

  // Writes to x0 are dropped; nothing is written or bypassed while reset is held.
  for (genvar k = 0; k < NWR; k++) begin : gWrite
    assign wAddr[k]   = bus.wr_addr[k*AW +: AW];
    assign wData[k]   = bus.wr_data[k*XLEN +: XLEN];
    assign wrValid[k] = reset && bus.wr_en[k]
                        && !(ZERO_R0 && (wAddr[k] == AW'(rv_pkg::REG_ZERO)));
  end

  // Later ports override earlier ones on an address collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < NWR; k++) begin
        if (wrValid[k]) begin
          regs[wAddr[k]] <= wData[k];
        end
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : gRead
    logic [AW-1:0]   rAddr;
    logic [XLEN-1:0] rVal;

    assign rAddr = bus.rd_addr[p*AW +: AW];

    always_comb begin
      rVal = regs[rAddr];
      if (BYPASS) begin
        for (int unsigned k = 0; k < NWR; k++) begin
          if (wrValid[k] && (wAddr[k] == rAddr)) begin
            rVal = wData[k];
          end
        end
      end
      if (ZERO_R0 && (rAddr == AW'(rv_pkg::REG_ZERO))) begin
        rVal = '0;
      end
    end

    assign bus.rd_data[p*XLEN +: XLEN] = rVal;
  end

  regfile_scoreboard #(
    .NREG    (NREG),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_R0 (ZERO_R0)
  ) uScoreboard (
    .clk        (clk),
    .reset      (reset),
    .wrValid    (wrValid),
    .wrAddrFlat (bus.wr_addr),
    .sbSet      (bus.sb_set),
    .sbAddr     (bus.sb_addr),
    .rdAddrFlat (bus.rd_addr),
    .rdBusy     (bus.rd_busy),
    .busyCnt    (bus.busy_cnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three configurations (bypass, no bypass, two write ports) share one stimulus
// stream and are compared every cycle against an array model, plus directed literal checks.
module tb_regfile_mp;

  logic clk;
  logic reset;
  logic checkOn;
  int   nChecks;
  int   nErrors;

  logic [4:0]  rdAddr [2];
  logic [1:0]  wrEn;
  logic [4:0]  wrAddr [2];
  logic [31:0] wrData [2];
  logic        sbSet;
  logic [4:0]  sbAddr;

  regfile_mp_if #(.NWR(1)) if0 ();
  regfile_mp_if #(.NWR(1)) if1 ();
  regfile_mp_if #(.NWR(2)) if2 ();

  assign if0.rd_addr = {rdAddr[1], rdAddr[0]};
  assign if0.wr_en   = wrEn[0];
  assign if0.wr_addr = wrAddr[0];
  assign if0.wr_data = wrData[0];
  assign if0.sb_set  = sbSet;
  assign if0.sb_addr = sbAddr;

  assign if1.rd_addr = {rdAddr[1], rdAddr[0]};
  assign if1.wr_en   = wrEn[0];
  assign if1.wr_addr = wrAddr[0];
  assign if1.wr_data = wrData[0];
  assign if1.sb_set  = sbSet;
  assign if1.sb_addr = sbAddr;

  assign if2.rd_addr = {rdAddr[1], rdAddr[0]};
  assign if2.wr_en   = wrEn;
  assign if2.wr_addr = {wrAddr[1], wrAddr[0]};
  assign if2.wr_data = {wrData[1], wrData[0]};
  assign if2.sb_set  = sbSet;
  assign if2.sb_addr = sbAddr;

  regfile_mp #(.NWR(1), .BYPASS(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  regfile_mp #(.NWR(1), .BYPASS(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));
  regfile_mp #(.NWR(2), .BYPASS(1'b1)) dut2 (.clk(clk), .reset(reset), .bus(if2));

  logic [63:0] rdO  [3];
  logic [1:0]  bsyO [3];
  logic [5:0]  cntO [3];

  assign rdO[0] = if0.rd_data;  assign bsyO[0] = if0.rd_busy;  assign cntO[0] = if0.busy_cnt;
  assign rdO[1] = if1.rd_data;  assign bsyO[1] = if1.rd_busy;  assign cntO[1] = if1.busy_cnt;
  assign rdO[2] = if2.rd_data;  assign bsyO[2] = if2.rd_busy;  assign cntO[2] = if2.busy_cnt;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: architectural register contents and busy bits per configuration.
  logic [31:0] mRegs [3][32];
  logic        mBusy [3][32];

  function automatic int nwrOf(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++)
        for (int r = 0; r < 32; r++) begin
          mRegs[i][r] <= '0;
          mBusy[i][r] <= 1'b0;
        end
    end else begin
      for (int i = 0; i < 3; i++) begin
        for (int k = 0; k < nwrOf(i); k++)
          if (wrEn[k] && wrAddr[k] != 5'd0) begin
            mRegs[i][wrAddr[k]] <= wrData[k];
            mBusy[i][wrAddr[k]] <= 1'b0;
          end
        if (sbSet && sbAddr != 5'd0) mBusy[i][sbAddr] <= 1'b1;
      end
    end
  end

  function automatic logic [31:0] expRead(input int i, input logic [4:0] a);
    logic [31:0] v;
    if (!reset || a == 5'd0) return 32'd0;
    v = mRegs[i][a];
    if (i != 1)
      for (int k = 0; k < nwrOf(i); k++)
        if (wrEn[k] && wrAddr[k] == a) v = wrData[k];
    return v;
  endfunction

  function automatic int expCnt(input int i);
    int c = 0;
    for (int r = 0; r < 32; r++) c += int'(mBusy[i][r]);
    return c;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkOn) begin
      for (int i = 0; i < 3; i++) begin
        for (int p = 0; p < 2; p++) begin
          check($sformatf("dut%0d_rd_data%0d", i, p), 64'(rdO[i][p*32 +: 32]),
                64'(expRead(i, rdAddr[p])));
          check($sformatf("dut%0d_rd_busy%0d", i, p), 64'(bsyO[i][p]),
                64'(mBusy[i][rdAddr[p]]));
        end
        check($sformatf("dut%0d_busy_cnt", i), 64'(cntO[i]), 64'(expCnt(i)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wrEn  = 2'b00;
    sbSet = 1'b0;
  endtask

  initial begin
    nChecks = 0;
    nErrors = 0;
    checkOn = 1'b0;
    reset   = 1'b0;
    rdAddr[0] = 5'd0; rdAddr[1] = 5'd0;
    wrAddr[0] = 5'd0; wrAddr[1] = 5'd0;
    wrData[0] = 32'd0; wrData[1] = 32'd0;
    idle();
    sbAddr = 5'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rd_data", rdO[0], 64'd0);
    check("reset_busy_cnt", 64'(cntO[0]), 64'd0);
    tick();
    reset   = 1'b1;
    checkOn = 1'b1;

    // Preload x5 and reserve x6, then reset mid-cycle.
    wrEn = 2'b01; wrAddr[0] = 5'd5; wrData[0] = 32'hDEAD_BEEF;
    sbSet = 1'b1; sbAddr = 5'd6; rdAddr[0] = 5'd5;
    tick();
    idle();
    @(negedge clk);
    check("x5_preload", 64'(rdO[0][31:0]), 64'hDEAD_BEEF);
    check("cnt_preload", 64'(cntO[0]), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("x5_reset_now", 64'(rdO[0][31:0]), 64'd0);
    check("cnt_reset_now", 64'(cntO[0]), 64'd0);
    wrEn = 2'b01; wrAddr[0] = 5'd5; wrData[0] = 32'h5555_5555;
    @(negedge clk);
    check("x5_held_in_reset", 64'(rdO[0][31:0]), 64'd0);
    idle();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("x5_after_reset", 64'(rdO[0][31:0]), 64'd0);
    tick();

    // Bypass vs no-bypass on a single write.
    wrEn = 2'b01; wrAddr[0] = 5'd7; wrData[0] = 32'h1234_5678; rdAddr[0] = 5'd7;
    @(negedge clk);
    check("x7_bypass", 64'(rdO[0][31:0]), 64'h1234_5678);
    check("x7_nobypass_old", 64'(rdO[1][31:0]), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("x7_nobypass_new", 64'(rdO[1][31:0]), 64'h1234_5678);
    tick();

    // x0 ignores writes and reservations.
    wrEn = 2'b01; wrAddr[0] = 5'd0; wrData[0] = 32'hFFFF_FFFF;
    sbSet = 1'b1; sbAddr = 5'd0; rdAddr[0] = 5'd0;
    @(negedge clk);
    check("x0_bypass_zero", 64'(rdO[0][31:0]), 64'd0);
    tick();
    idle();
    @(negedge clk);
    check("x0_read_zero", 64'(rdO[2][31:0]), 64'd0);
    check("x0_not_busy", 64'(bsyO[0][0]), 64'd0);
    check("x0_cnt", 64'(cntO[0]), 64'd0);
    tick();

    // Two write ports on the same register: port 1 wins.
    wrEn = 2'b11; wrAddr[0] = 5'd10; wrData[0] = 32'hA; wrAddr[1] = 5'd10; wrData[1] = 32'hB;
    rdAddr[1] = 5'd10;
    @(negedge clk);
    check("x10_collide_bypass", 64'(rdO[2][63:32]), 64'hB);
    tick();
    idle();
    @(negedge clk);
    check("x10_collide_stored", 64'(rdO[2][63:32]), 64'hB);
    check("x10_single_port", 64'(rdO[0][63:32]), 64'hA);
    tick();

    // Scoreboard set, set-with-clear, clear.
    sbSet = 1'b1; sbAddr = 5'd3; rdAddr[0] = 5'd3;
    tick();
    idle();
    @(negedge clk);
    check("x3_busy_set", 64'(bsyO[0][0]), 64'd1);
    check("x3_cnt_set", 64'(cntO[0]), 64'd1);
    tick();
    wrEn = 2'b01; wrAddr[0] = 5'd3; wrData[0] = 32'h33; sbSet = 1'b1; sbAddr = 5'd3;
    tick();
    idle();
    @(negedge clk);
    check("x3_busy_setwins", 64'(bsyO[0][0]), 64'd1);
    check("x3_cnt_setwins", 64'(cntO[0]), 64'd1);
    tick();
    wrEn = 2'b01; wrAddr[0] = 5'd3; wrData[0] = 32'h34;
    tick();
    idle();
    @(negedge clk);
    check("x3_busy_clear", 64'(bsyO[0][0]), 64'd0);
    check("x3_cnt_clear", 64'(cntO[0]), 64'd0);
    tick();

    // Random soak with small-address bias for collisions, and one mid-run reset.
    for (int n = 0; n < 10000; n++) begin
      for (int p = 0; p < 2; p++)
        rdAddr[p] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wrEn = 2'($urandom_range(0, 3));
      for (int k = 0; k < 2; k++) begin
        wrAddr[k] = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
        wrData[k] = $urandom;
      end
      sbSet  = 1'($urandom_range(0, 1));
      sbAddr = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      if (n == 5000) begin
        #2 reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
      end else begin
        tick();
      end
    end
    idle();
    @(negedge clk);
    checkOn = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
